// File: rtl/wav_frame_reader_pkg.sv
// Shared definitions for the sample BRAM frame reader: FSM state encoding,
// default geometry and the frame-count helper.
package wav_frame_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } rd_state_e;

  localparam int unsigned DEF_DWIDTH    = 30;
  localparam int unsigned DEF_AWIDTH    = 9;
  localparam int unsigned DEF_WORDS     = 400;
  localparam int unsigned DEF_FRAME_LEN = 200;
  localparam int unsigned DEF_HOP       = 100;

  // Only complete frames are emitted.
  function automatic int unsigned frame_count(input int unsigned words,
                                              input int unsigned flen,
                                              input int unsigned hop);
    return (words - flen) / hop + 1;
  endfunction

endpackage

// File: rtl/wav_frame_reader_skid.sv
// frame_skid_buf: 2-entry registered FIFO carrying {data,sof,eof}; entry 0 is
// the head and drives the outputs directly.
module frame_skid_buf #(
  parameter int unsigned DWIDTH = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic              pop,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_sof,
  output logic              out_eof,
  output logic [1:0]        count
);

  logic [DWIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic              sof0_q, sof0_d, sof1_q, sof1_d;
  logic              eof0_q, eof0_d, eof1_q, eof1_d;
  logic [1:0]        count_q, count_d;
  logic              pop_ok_s;

  // Next-state for the two entries and the occupancy counter.
  always_comb begin
    data0_d  = data0_q;
    data1_d  = data1_q;
    sof0_d   = sof0_q;
    sof1_d   = sof1_q;
    eof0_d   = eof0_q;
    eof1_d   = eof1_q;
    count_d  = count_q;
    pop_ok_s = pop & (count_q != 2'd0);
    case ({push, pop_ok_s})
      2'b10: begin
        if (count_q == 2'd0) begin
          data0_d = in_data; sof0_d = in_sof; eof0_d = in_eof;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          data1_d = in_data; sof1_d = in_sof; eof1_d = in_eof;
          count_d = 2'd2;
        end else begin
          count_d = count_q;
        end
      end
      2'b01: begin
        data0_d = data1_q; sof0_d = sof1_q; eof0_d = eof1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          data0_d = in_data; sof0_d = in_sof; eof0_d = in_eof;
        end else begin
          data0_d = data1_q; sof0_d = sof1_q; eof0_d = eof1_q;
          data1_d = in_data; sof1_d = in_sof; eof1_d = in_eof;
        end
      end
      default: count_d = count_q;
    endcase
  end

  // Entry and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data0_q <= {DWIDTH{1'b0}}; data1_q <= {DWIDTH{1'b0}};
      sof0_q  <= 1'b0; sof1_q <= 1'b0;
      eof0_q  <= 1'b0; eof1_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      data0_q <= data0_d; data1_q <= data1_d;
      sof0_q  <= sof0_d;  sof1_q  <= sof1_d;
      eof0_q  <= eof0_d;  eof1_q  <= eof1_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = data0_q;
  assign out_sof   = sof0_q;
  assign out_eof   = eof0_q;
  assign count     = count_q;

endmodule

// File: rtl/wav_frame_reader.sv
// Walks the sample BRAM as overlapping frames and streams them over valid/ready.
// Optional feature: define PREEMPH_EN for a saturating pre-emphasis stage.
module wav_frame_reader
  import wav_frame_reader_pkg::*;
#(
  parameter int unsigned DWIDTH    = DEF_DWIDTH,
  parameter int unsigned AWIDTH    = DEF_AWIDTH,
  parameter int unsigned WORDS     = DEF_WORDS,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
  parameter int unsigned HOP       = DEF_HOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic [7:0]        frame_idx
);

  localparam int unsigned NFRAMES = frame_count(WORDS, FRAME_LEN, HOP);

  rd_state_e         state_q, state_d;
  logic [AWIDTH-1:0] base_q, base_d, cnt_q, cnt_d, mem_addr_q, mem_addr_d;
  logic [7:0]        frame_idx_q, frame_idx_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              iss_q, iss_d, iss_sof_q, iss_sof_d, iss_eof_q, iss_eof_d;
  logic              rd_q, rd_sof_q, rd_eof_q;
  logic              push_s, push_sof_s, push_eof_s, land_s, pop_s, can_issue_s;
  logic [DWIDTH-1:0] push_data_s;
  logic [2:0]        occ_next_s, inflight_s;
  logic              sk_valid_s, sk_sof_s, sk_eof_s;
  logic [DWIDTH-1:0] sk_data_s;
  logic [1:0]        sk_count_s;

  assign pop_s = sk_valid_s & out_ready;

  // A read may only be issued if every sample already in the pipe plus this one
  // still fits in the skid buffer assuming the sink stalls from now on.
  always_comb begin
    occ_next_s  = {1'b0, sk_count_s} - {2'b00, pop_s} + {2'b00, land_s};
    can_issue_s = ((occ_next_s + inflight_s) < 3'd2);
  end

  // Frame walk FSM next-state.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    frame_idx_d = frame_idx_q;
    mem_addr_d  = mem_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    iss_d       = 1'b0;
    iss_sof_d   = 1'b0;
    iss_eof_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_FETCH;
          base_d      = {AWIDTH{1'b0}};
          cnt_d       = {AWIDTH{1'b0}};
          frame_idx_d = 8'd0;
          busy_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (can_issue_s) begin
          mem_addr_d = base_q + cnt_q;
          iss_d      = 1'b1;
          iss_sof_d  = (cnt_q == {AWIDTH{1'b0}});
          iss_eof_d  = (cnt_q == AWIDTH'(FRAME_LEN - 1));
          if (cnt_q == AWIDTH'(FRAME_LEN - 1)) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + AWIDTH'(1);
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (pop_s && sk_eof_s) begin
          if (frame_idx_q == 8'(NFRAMES - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_NEXT;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_NEXT: begin
        base_d      = base_q + AWIDTH'(HOP);
        cnt_d       = {AWIDTH{1'b0}};
        frame_idx_d = frame_idx_q + 8'd1;
        state_d     = ST_FETCH;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, address and read-tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= {AWIDTH{1'b0}};
      cnt_q       <= {AWIDTH{1'b0}};
      frame_idx_q <= 8'd0;
      mem_addr_q  <= {AWIDTH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      iss_q       <= 1'b0;
      iss_sof_q   <= 1'b0;
      iss_eof_q   <= 1'b0;
      rd_q        <= 1'b0;
      rd_sof_q    <= 1'b0;
      rd_eof_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      frame_idx_q <= frame_idx_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      iss_q       <= iss_d;
      iss_sof_q   <= iss_sof_d;
      iss_eof_q   <= iss_eof_d;
      rd_q        <= iss_q;
      rd_sof_q    <= iss_sof_q;
      rd_eof_q    <= iss_eof_q;
    end
  end

`ifdef PREEMPH_EN
  logic              pe_q, pe_sof_q, pe_eof_q;
  logic [DWIDTH-1:0] pe_data_q, pe_data_d, xprev_q;
  logic signed [DWIDTH+1:0] x_s, xp_s, y_s;

  function automatic logic [DWIDTH-1:0] sat_dw(input logic signed [DWIDTH+1:0] v);
    logic signed [DWIDTH+1:0] maxv, minv;
    maxv = {3'b000, {(DWIDTH-1){1'b1}}};
    minv = {3'b111, {(DWIDTH-1){1'b0}}};
    if (v > maxv) begin
      return maxv[DWIDTH-1:0];
    end else if (v < minv) begin
      return minv[DWIDTH-1:0];
    end else begin
      return v[DWIDTH-1:0];
    end
  endfunction

  // y = x[n] - x[n-1] + x[n-1]/32 with x[-1] forced to zero at each frame start.
  always_comb begin
    x_s = {{2{mem_rdata[DWIDTH-1]}}, mem_rdata};
    if (rd_sof_q) begin
      xp_s = {(DWIDTH+2){1'b0}};
    end else begin
      xp_s = {{2{xprev_q[DWIDTH-1]}}, xprev_q};
    end
    y_s       = x_s - xp_s + (xp_s >>> 3'd5);
    pe_data_d = sat_dw(y_s);
  end

  // Pre-emphasis output stage and previous-sample register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pe_q      <= 1'b0;
      pe_sof_q  <= 1'b0;
      pe_eof_q  <= 1'b0;
      pe_data_q <= {DWIDTH{1'b0}};
      xprev_q   <= {DWIDTH{1'b0}};
    end else begin
      pe_q     <= rd_q;
      pe_sof_q <= rd_sof_q;
      pe_eof_q <= rd_eof_q;
      if (rd_q) begin
        pe_data_q <= pe_data_d;
        xprev_q   <= mem_rdata;
      end else begin
        pe_data_q <= pe_data_q;
        xprev_q   <= xprev_q;
      end
    end
  end

  assign push_s      = pe_q;
  assign push_data_s = pe_data_q;
  assign push_sof_s  = pe_sof_q;
  assign push_eof_s  = pe_eof_q;
  assign land_s      = pe_q;
  assign inflight_s  = {2'b00, iss_q} + {2'b00, rd_q};
`else
  assign push_s      = rd_q;
  assign push_data_s = mem_rdata;
  assign push_sof_s  = rd_sof_q;
  assign push_eof_s  = rd_eof_q;
  assign land_s      = rd_q;
  assign inflight_s  = {2'b00, iss_q};
`endif

  frame_skid_buf #(.DWIDTH(DWIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .in_data   (push_data_s),
    .in_sof    (push_sof_s),
    .in_eof    (push_eof_s),
    .pop       (pop_s),
    .out_valid (sk_valid_s),
    .out_data  (sk_data_s),
    .out_sof   (sk_sof_s),
    .out_eof   (sk_eof_s),
    .count     (sk_count_s)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = mem_addr_q;
  assign frame_idx = frame_idx_q;
  assign out_valid = sk_valid_s;
  assign out_data  = sk_data_s;
  assign out_sof   = sk_sof_s;
  assign out_eof   = sk_eof_s;

endmodule

// File: tb/tb_wav_frame_reader.sv
// Scoreboard bench for wav_frame_reader: default geometry plus FRAME_LEN=400/HOP=7
// and FRAME_LEN=1/HOP=399 instances sharing one sample memory.
module tb_wav_frame_reader;
  localparam int DW = 30;
  localparam int AW = 9;
  localparam int WORDS = 400;
  localparam int NI = 3;
`ifdef PREEMPH_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [NI-1:0] start, busy, done, out_valid, out_ready, out_sof, out_eof;
  logic [AW-1:0] mem_addr [NI];
  logic [DW-1:0] mem_rdata [NI];
  logic [DW-1:0] out_data [NI];
  logic [7:0]    frame_idx [NI];
  logic [DW-1:0] mem [0:WORDS-1];

  wav_frame_reader u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]), .out_data(out_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sof(out_sof[0]),
    .out_eof(out_eof[0]), .frame_idx(frame_idx[0]));

  wav_frame_reader #(.FRAME_LEN(400), .HOP(7)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]), .out_data(out_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sof(out_sof[1]),
    .out_eof(out_eof[1]), .frame_idx(frame_idx[1]));

  wav_frame_reader #(.FRAME_LEN(1), .HOP(399)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .mem_addr(mem_addr[2]), .mem_rdata(mem_rdata[2]), .out_data(out_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sof(out_sof[2]),
    .out_eof(out_eof[2]), .frame_idx(frame_idx[2]));

  // BRAM model with one-cycle registered read.
  always @(posedge clk)
    for (int i = 0; i < NI; i++)
      mem_rdata[i] <= (int'(mem_addr[i]) < WORDS) ? mem[mem_addr[i]] : '0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          eof;
    logic [7:0]    fidx;
  } exp_t;

  exp_t exp_q [NI][$];
  exp_t held [NI];
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt [NI] = '{0, 0, 0};
  int   done_cnt [NI] = '{0, 0, 0};
  int   ready_mode [NI] = '{0, 0, 0};
  logic [NI-1:0] prev_stall = '0;
  bit   addr_bad = 1'b0;

  function automatic int fl_of(input int i);
    case (i)
      0: return 200;
      1: return 400;
      default: return 1;
    endcase
  endfunction

  function automatic int hp_of(input int i);
    case (i)
      0: return 100;
      1: return 7;
      default: return 399;
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: every full frame in order, each sample straight from memory
  // (or filtered against the previous memory word when pre-emphasis is built in).
  task automatic model(input int inst);
    int fl, hp, nf, a;
    longint x, xp, y;
    exp_t e;
    fl = fl_of(inst);
    hp = hp_of(inst);
    nf = (WORDS - fl) / hp + 1;
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < fl; i++) begin
        a = f * hp + i;
        x = $signed(mem[a]);
`ifdef PREEMPH_EN
        xp = (i == 0) ? 64'sd0 : $signed(mem[a-1]);
        y  = x - xp + (xp >>> 5);
        if (y > (64'sd1 <<< 29) - 1) y = (64'sd1 <<< 29) - 1;
        if (y < -(64'sd1 <<< 29)) y = -(64'sd1 <<< 29);
`else
        xp = 64'sd0;
        y  = x + xp;
`endif
        e.data = y[DW-1:0];
        e.sof  = (i == 0);
        e.eof  = (i == fl - 1);
        e.fidx = 8'(f);
        exp_q[inst].push_back(e);
      end
    end
  endtask

  // Sink ready pattern per instance.
  initial begin
    out_ready = '1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++)
        out_ready[i] = (ready_mode[i] != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks hold during stalls.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        prev_stall[i] = 1'b0;
      end else begin
        if (prev_stall[i]) begin
          check($sformatf("hold i%0d", i),
                {out_valid[i], out_data[i], out_sof[i], out_eof[i], frame_idx[i]},
                {1'b1, held[i].data, held[i].sof, held[i].eof, held[i].fidx});
        end
        if (out_valid[i] && out_ready[i]) begin
          acc_cnt[i]++;
          if (exp_q[i].size() == 0) begin
            check($sformatf("unexpected sample i%0d", i), 1, 0);
          end else begin
            exp_t e;
            e = exp_q[i].pop_front();
            check($sformatf("data i%0d n%0d", i, acc_cnt[i]), out_data[i], e.data);
            check($sformatf("sof i%0d n%0d", i, acc_cnt[i]), out_sof[i], e.sof);
            check($sformatf("eof i%0d n%0d", i, acc_cnt[i]), out_eof[i], e.eof);
            check($sformatf("frame_idx i%0d n%0d", i, acc_cnt[i]), frame_idx[i], e.fidx);
          end
        end
        prev_stall[i] = out_valid[i] && !out_ready[i];
        held[i] = '{out_data[i], out_sof[i], out_eof[i], frame_idx[i]};
        if (done[i]) done_cnt[i]++;
        if (int'(mem_addr[i]) >= WORDS) addr_bad = 1'b1;
      end
    end
  end

  task automatic pulse_start(input int inst);
    @(posedge clk); #1 start[inst] = 1'b1;
    @(posedge clk); #1 start[inst] = 1'b0;
  endtask

  task automatic run_pass(input int inst, input int mode, input bit restarts);
    int d0, lat, cyc;
    ready_mode[inst] = mode;
    model(inst);
    d0 = done_cnt[inst];
    pulse_start(inst);
    lat = 0;
    @(negedge clk);
    while (!out_valid[inst] && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check($sformatf("first valid latency i%0d", inst), lat, LAT);
    check($sformatf("busy in pass i%0d", inst), busy[inst], 1);
    cyc = 0;
    while (done_cnt[inst] == d0 && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      start[inst] = restarts && (cyc % 97 == 0);
    end
    start[inst] = 1'b0;
    check($sformatf("pass finished i%0d", inst), (cyc < 20000) ? 1 : 0, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check($sformatf("all samples seen i%0d", inst), exp_q[inst].size(), 0);
    check($sformatf("done pulses i%0d", inst), done_cnt[inst] - d0, 1);
    check($sformatf("busy after i%0d", inst), busy[inst], 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, cyc;
    rst = 1'b1;
    start = '0;
    for (int i = 0; i < WORDS; i++) mem[i] = DW'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy[0], 0);
    check("reset done", done[0], 0);
    check("reset out_valid", out_valid[0], 0);
    check("reset out_sof", out_sof[0], 0);
    check("reset out_eof", out_eof[0], 0);
    check("reset out_data", out_data[0], 0);
    check("reset mem_addr", mem_addr[0], 0);
    check("reset frame_idx", frame_idx[0], 0);
    @(posedge clk); #1 rst = 1'b0;

    run_pass(0, 0, 1'b0);
    run_pass(0, 1, 1'b0);
    run_pass(0, 0, 1'b1);

    // Reset at sample 150 of frame 1, then a fresh pass must start from frame 0.
    ready_mode[0] = 0;
    model(0);
    a0 = acc_cnt[0];
    pulse_start(0);
    cyc = 0;
    while (acc_cnt[0] < a0 + 350 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("reached frame1 sample150", (acc_cnt[0] >= a0 + 350) ? 1 : 0, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid reset out_valid", out_valid[0], 0);
    check("mid reset busy", busy[0], 0);
    check("mid reset frame_idx", frame_idx[0], 0);
    @(posedge clk); #1 rst = 1'b0;
    exp_q[0].delete();
    run_pass(0, 0, 1'b0);

    for (int i = 0; i < WORDS; i++) mem[i] = DW'($urandom);
    run_pass(0, 1, 1'b0);
`ifdef PREEMPH_EN
    for (int i = 0; i < WORDS; i++) mem[i] = DW'(1000);
    run_pass(0, 1, 1'b0);
    for (int i = 0; i < WORDS; i++) mem[i] = (i % 2 == 0) ? 30'h1FFF_FFFF : 30'h2000_0000;
    run_pass(0, 0, 1'b0);
`endif

    for (int i = 0; i < WORDS; i++) mem[i] = DW'(i);
    run_pass(1, 1, 1'b0);
    run_pass(2, 1, 1'b0);

    check("address range", addr_bad ? 1 : 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
